rs_encoder: RTL and testbench

Systematic Reed-Solomon encoder over GF(2^8) for the t=3 code whose decoder computes syndromes S1..S6 at α^1..α^6 and solves for σ(x). Accepts K data symbols on a valid/ready stream, forwards them unchanged, then appends six parity symbols. The resulting codeword yields all-zero syndromes at the decoder. This block is the transmit end of the RS link and feeds the channel/interleaver.

---
 rtl/rs_pkg.sv | 15 +
 rtl/rs_encoder_multiply.sv | 22 ++
 rtl/rs_encoder.sv | 107 ++++++++++
 tb/tb_rs_encoder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared constants for the RS(K+6,K) t=3 encoder over GF(2^8), field polynomial 0x11D.
package rs_pkg;

  localparam logic [7:0]  GF_POLY = 8'h1D;
  localparam int unsigned RS_NPAR = 6;

  // g(x) = prod_{i=1..6} (x + alpha^i); index i holds the coefficient of x^i, x^6 is implicit
  localparam logic [7:0] G_COEF [0:5] = '{8'h75, 8'h31, 8'h3A, 8'h9E, 8'h04, 8'h7E};

  typedef enum logic {
    DATA,
    PARITY
  } rs_state_e;

endpackage

// File: rtl/rs_encoder_multiply.sv
// GF(2^8) multiplier X = A*B, reduced by the field polynomial, purely combinational.
module multiply
  import rs_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] X
);

  always_comb begin
    logic [7:0] a;
    logic [7:0] p;
    a = A;
    p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (B[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    end
    X = p;
  end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS encoder: forwards K data symbols, then appends parity p5..p0 from an LFSR.
module rs_encoder
  import rs_pkg::*;
#(
  parameter int unsigned K = 249
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_parity,
  output logic       out_last
);

  // Also counts the six parity slots, so never narrower than 3 bits
  localparam int unsigned CW = ($clog2(K) > 3) ? $clog2(K) : 3;

  rs_state_e     r_state;
  rs_state_e     w_next_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_par [0:RS_NPAR-1];
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic          r_out_parity;
  logic          r_out_last;

  logic          w_free;
  logic          w_accept;
  logic          w_par_load;
  logic          w_last_data;
  logic          w_last_par;
  logic [7:0]    w_fb;
  logic [7:0]    w_prod [0:RS_NPAR-1];

  assign w_free      = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_par_load  = (r_state == PARITY) && w_free;
  assign w_last_data = w_accept && (r_cnt == CW'(K - 1));
  assign w_last_par  = w_par_load && (r_cnt == CW'(RS_NPAR - 1));
  assign w_fb        = in_data ^ r_par[RS_NPAR-1];

  for (genvar gi = 0; gi < RS_NPAR; gi++) begin : g_mul
    multiply u_mul (
      .A (w_fb),
      .B (G_COEF[gi]),
      .X (w_prod[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DATA;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DATA:    if (w_last_data) w_next_state = PARITY;
      PARITY:  if (w_last_par)  w_next_state = DATA;
      default: w_next_state = DATA;
    endcase
  end

  always_comb begin
    in_ready = (r_state == DATA) && w_free;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_parity <= 1'b0;
      r_out_last   <= 1'b0;
      for (int unsigned i = 0; i < RS_NPAR; i++) r_par[i] <= '0;
    end else if (w_accept) begin
      for (int unsigned i = 1; i < RS_NPAR; i++) r_par[i] <= r_par[i-1] ^ w_prod[i];
      r_par[0]     <= w_prod[0];
      r_out_valid  <= 1'b1;
      r_out_data   <= in_data;
      r_out_parity <= 1'b0;
      r_out_last   <= 1'b0;
      r_cnt        <= w_last_data ? '0 : r_cnt + 1'b1;
    end else if (w_par_load) begin
      // Shifting zeros in leaves the register clear once p0 has left
      for (int unsigned i = 1; i < RS_NPAR; i++) r_par[i] <= r_par[i-1];
      r_par[0]     <= '0;
      r_out_valid  <= 1'b1;
      r_out_data   <= r_par[RS_NPAR-1];
      r_out_parity <= 1'b1;
      r_out_last   <= w_last_par;
      r_cnt        <= w_last_par ? '0 : r_cnt + 1'b1;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_parity = r_out_parity;
  assign out_last   = r_out_last;

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: long-division parity model, scoreboard, and syndrome checks at alpha^1..alpha^6.
module tb_rs_encoder;

  localparam int unsigned K = 249;
  localparam int unsigned N = K + 6;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_parity, out_last;
  logic [7:0] in_data, out_data;
  logic       s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready, s1_out_parity, s1_out_last;
  logic [7:0] s1_in_data, s1_out_data;
  logic       s4_in_valid, s4_in_ready, s4_out_valid, s4_out_ready, s4_out_parity, s4_out_last;
  logic [7:0] s4_in_data, s4_out_data;

  rs_encoder #(.K(K)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .out_last(out_last)
  );

  rs_encoder #(.K(1)) u_k1 (
    .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
    .out_parity(s1_out_parity), .out_last(s1_out_last)
  );

  rs_encoder #(.K(4)) u_k4 (
    .clk(clk), .rst(rst), .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_data(s4_in_data),
    .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_data(s4_out_data),
    .out_parity(s4_out_parity), .out_last(s4_out_last)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_cw    = 0;
  int unsigned rdy_pct = 100;

  logic [7:0] gb [0:6];
  exp_t       sb [$];
  logic [7:0] cur_msg [$];
  logic [7:0] cw [$];
  logic [7:0] cap [$];
  logic       stall_prev = 1'b0;
  logic       par_phase  = 1'b0;
  logic [7:0] held_d;
  logic       held_p, held_l;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] apow(input int n);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < n; i++) v = gmul(v, 8'h02);
    return v;
  endfunction

  function automatic void build_gen();
    for (int i = 0; i <= 6; i++) gb[i] = 8'h00;
    gb[0] = 8'h01;
    for (int i = 1; i <= 6; i++)
      for (int j = i; j >= 1; j--) gb[j] = gb[j] ^ gmul(apow(i), gb[j-1]);
  endfunction

  function automatic void calc_parity(input logic [7:0] msg [$], output logic [7:0] par [0:5]);
    logic [7:0] d [$];
    logic [7:0] coef;
    d = msg;
    for (int i = 0; i < 6; i++) d.push_back(8'h00);
    for (int i = 0; i < msg.size(); i++) begin
      coef = d[i];
      for (int j = 1; j <= 6; j++) d[i+j] = d[i+j] ^ gmul(coef, gb[j]);
    end
    for (int k = 0; k < 6; k++) par[k] = d[msg.size() + k];
  endfunction

  function automatic logic [7:0] synd(input logic [7:0] c [$], input int j);
    logic [7:0] s, aj;
    aj = apow(j);
    s  = 8'h00;
    foreach (c[k]) s = gmul(s, aj) ^ c[k];
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
  end

  // Scoreboard monitor on the K=249 instance
  always @(negedge clk) begin
    logic [7:0] par [0:5];
    exp_t e;
    if (rst) begin
      sb.delete(); cur_msg.delete(); cw.delete();
      stall_prev = 1'b0;
      par_phase  = 1'b0;
    end else begin
      n_total++;
      if (par_phase && !(out_valid && out_last)) begin
        if (in_ready !== 1'b0) $display("FAIL in_ready_parity: got %b want 0", in_ready);
        else n_pass++;
      end else begin
        if (in_ready !== (!out_valid || out_ready))
          $display("FAIL in_ready_free: got %b want %b", in_ready, (!out_valid || out_ready));
        else n_pass++;
      end
      if (stall_prev) begin
        n_total++;
        if ({out_valid, out_data, out_parity, out_last} !== {1'b1, held_d, held_p, held_l})
          $display("FAIL stall_hold: got v%b d%h p%b l%b want v1 d%h p%b l%b",
                   out_valid, out_data, out_parity, out_last, held_d, held_p, held_l);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_extra: got d%h with nothing expected", out_data);
        end else begin
          e = sb.pop_front();
          if ({out_data, out_parity, out_last} !== {e.d, e.p, e.l})
            $display("FAIL sb_symbol: got d%h p%b l%b want d%h p%b l%b",
                     out_data, out_parity, out_last, e.d, e.p, e.l);
          else n_pass++;
        end
        cap.push_back(out_data);
        cw.push_back(out_data);
        if (out_last) begin
          for (int j = 1; j <= 6; j++) begin
            n_total++;
            if (synd(cw, j) !== 8'h00 || cw.size() != N)
              $display("FAIL syndrome: S%0d got %h (len %0d) want 00 (len %0d)", j, synd(cw, j), cw.size(), N);
            else n_pass++;
          end
          cw.delete();
          n_cw++;
        end
      end
      stall_prev = out_valid && !out_ready;
      held_d = out_data; held_p = out_parity; held_l = out_last;
      if (out_valid && out_last) par_phase = 1'b0;
      if (in_valid && in_ready) begin
        sb.push_back(exp_t'{in_data, 1'b0, 1'b0});
        cur_msg.push_back(in_data);
        if (cur_msg.size() == K) begin
          calc_parity(cur_msg, par);
          for (int k = 0; k < 6; k++) sb.push_back(exp_t'{par[k], 1'b1, (k == 5)});
          cur_msg.delete();
          par_phase = 1'b1;
        end
      end
    end
  end

  task automatic send_msg(input logic [7:0] msg [$], input int unsigned gap_pct);
    logic acc;
    int   budget;
    foreach (msg[i]) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      budget   = 0;
      acc      = 1'b0;
      while (!acc && budget < 3000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) begin
        n_total++;
        $display("FAIL accept_timeout: got no accept after %0d cycles want accept", budget);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    n_total++;
    if (!done) $display("FAIL drain: got %0d pending want 0", sb.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({out_valid, out_data, out_parity, out_last, in_ready, s1_out_valid, s4_out_valid} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_state: got v%b d%h p%b l%b rdy%b want v0 d00 p0 l0 rdy1",
               out_valid, out_data, out_parity, out_last, in_ready);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_k1();
    logic [7:0] od [$];
    logic       op [$];
    logic       ol [$];
    logic [7:0] exp_d;
    s1_in_valid = 1'b1;
    s1_in_data  = 8'h01;
    @(negedge clk);
    n_total++;
    if (s1_in_ready !== 1'b1) $display("FAIL k1_ready: got %b want 1", s1_in_ready);
    else n_pass++;
    @(posedge clk); #1;
    s1_in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s1_out_valid) begin
        od.push_back(s1_out_data); op.push_back(s1_out_parity); ol.push_back(s1_out_last);
      end
    end
    n_total++;
    if (od.size() != 7) $display("FAIL k1_count: got %0d want 7", od.size());
    else n_pass++;
    for (int i = 0; i < 7 && i < od.size(); i++) begin
      exp_d = (i == 0) ? 8'h01 : gb[i];
      n_total++;
      if ({od[i], op[i], ol[i]} !== {exp_d, (i != 0), (i == 6)})
        $display("FAIL k1_sym%0d: got d%h p%b l%b want d%h p%b l%b",
                 i, od[i], op[i], ol[i], exp_d, (i != 0), (i == 6));
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_k4_back_to_back();
    logic [7:0] m [0:7];
    logic [7:0] od [$];
    int         oc [$];
    logic [19:0] lastv;
    logic [7:0] q [$];
    logic [7:0] c [$];
    logic [7:0] par [0:5];
    logic       acc;
    int         idx;
    m = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    lastv = '0;
    idx = 0;
    s4_in_valid = 1'b1;
    s4_in_data  = m[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (s4_out_valid) begin
        if (od.size() < 20) lastv[od.size()] = s4_out_last;
        od.push_back(s4_out_data); oc.push_back(cyc);
      end
      acc = s4_in_valid && s4_in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      s4_in_valid = (idx < 8);
      s4_in_data  = (idx < 8) ? m[idx] : 8'h00;
    end
    n_total++;
    if (od.size() != 20) $display("FAIL k4_count: got %0d want 20", od.size());
    else n_pass++;
    if (od.size() == 20) begin
      n_total++;
      if (oc[19] - oc[0] != 19) $display("FAIL k4_gapless: got span %0d want 19", oc[19] - oc[0]);
      else n_pass++;
      n_total++;
      if (lastv !== 20'h80200) $display("FAIL k4_last: got %h want 80200", lastv);
      else n_pass++;
      for (int w = 0; w < 2; w++) begin
        q.delete(); c.delete();
        for (int i = 0; i < 4; i++) q.push_back(m[4*w + i]);
        calc_parity(q, par);
        for (int i = 0; i < 10; i++) c.push_back(od[10*w + i]);
        for (int i = 0; i < 10; i++) begin
          n_total++;
          if (c[i] !== ((i < 4) ? q[i] : par[i-4]))
            $display("FAIL k4_cw%0d_sym%0d: got %h want %h", w, i, c[i], (i < 4) ? q[i] : par[i-4]);
          else n_pass++;
        end
        for (int j = 1; j <= 6; j++) begin
          n_total++;
          if (synd(c, j) !== 8'h00) $display("FAIL k4_cw%0d_S%0d: got %h want 00", w, j, synd(c, j));
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_zero();
    logic [7:0] q [$];
    int nz;
    rdy_pct = 100;
    cap.delete();
    for (int i = 0; i < K; i++) q.push_back(8'h00);
    send_msg(q, 0);
    drain();
    nz = 0;
    foreach (cap[i]) if (cap[i] != 8'h00) nz++;
    n_total++;
    if (cap.size() != N || nz != 0) $display("FAIL zero_msg: got %0d symbols, %0d nonzero want %0d, 0", cap.size(), nz, N);
    else n_pass++;
  endtask

  task automatic run_random(input int unsigned n_msgs, input int unsigned rpct, input int unsigned gap, input string tag);
    logic [7:0] q [$];
    int unsigned cw0;
    rdy_pct = rpct;
    cw0 = n_cw;
    for (int unsigned m = 0; m < n_msgs; m++) begin
      q.delete();
      for (int i = 0; i < K; i++) q.push_back(8'($urandom));
      send_msg(q, gap);
    end
    drain();
    n_total++;
    if (n_cw - cw0 != n_msgs) $display("FAIL %s_codewords: got %0d want %0d", tag, n_cw - cw0, n_msgs);
    else n_pass++;
    rdy_pct = 100;
  endtask

  task automatic test_random();
    run_random(12, 100, 10, "random");
  endtask

  task automatic test_backpressure();
    run_random(6, 30, 20, "backpressure");
  endtask

  task automatic test_reset_mid();
    logic [7:0] msg [$];
    logic [7:0] cap_a [$];
    int diffs;
    rdy_pct = 100;
    for (int i = 0; i < K; i++) msg.push_back(8'($urandom));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cap.delete();
    send_msg(msg, 0);
    drain();
    cap_a = cap;
    send_msg(msg[0:99], 0);
    rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid, out_data, out_parity, out_last, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_mid_state: got v%b d%h p%b l%b rdy%b want v0 d00 p0 l0 rdy1",
               out_valid, out_data, out_parity, out_last, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cap.delete();
    send_msg(msg, 0);
    drain();
    diffs = 0;
    for (int i = 0; i < cap.size() && i < cap_a.size(); i++) if (cap[i] !== cap_a[i]) diffs++;
    n_total++;
    if (cap.size() != N || cap_a.size() != N || diffs != 0)
      $display("FAIL reset_mid_repeat: got len %0d/%0d diffs %0d want len %0d diffs 0", cap.size(), cap_a.size(), diffs, N);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    s1_in_valid = 1'b0; s1_in_data = 8'h00; s1_out_ready = 1'b1;
    s4_in_valid = 1'b0; s4_in_data = 8'h00; s4_out_ready = 1'b1;
    build_gen();
    test_reset();
    test_k1();
    test_k4_back_to_back();
    test_zero();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
